// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared ALUControl codes, register-zero constant and forward-select
//            enum for the 5-stage MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/ex_issue_stage_fwd_sel.sv
// ============================================================================
// Module   : fwd_sel
// Purpose  : Chooses the operand source for one EX register-file read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_sel
   import mips_pkg::*;
#(
   parameter int RW = 5
) (
   input  logic [RW-1:0] src,
   input  logic          mem_reg_write,
   input  logic [RW-1:0] mem_rd,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] wb_rd,
   output fwd_sel_e      sel
);

   logic w_src_nonzero;

   assign w_src_nonzero = (src != RW'(REG_ZERO));

   // MEM holds the younger result, so it takes precedence over WB
   always_comb begin
      sel = FWD_RF;
      if (mem_reg_write && (mem_rd == src) && w_src_nonzero) begin
         sel = FWD_MEM;
      end else if (wb_reg_write && (wb_rd == src) && w_src_nonzero) begin
         sel = FWD_WB;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ex_issue_stage.sv
// ============================================================================
// Module   : ex_issue_stage
// Purpose  : ID/EX pipeline register with MEM/WB operand forwarding and
//            load-use detection. Forwarding is built when EX_FORWARD_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_issue_stage
   import mips_pkg::*;
#(
   parameter int DW = 32,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [DW-1:0] id_rs_val,
   input  logic [DW-1:0] id_rt_val,
   input  logic [RW-1:0] id_rs,
   input  logic [RW-1:0] id_rt,
   input  logic [RW-1:0] id_rd,
   input  logic [DW-1:0] id_imm,
   input  logic          id_alu_src,
   input  logic [2:0]    id_alu_op,
   input  logic          id_reg_write,
   input  logic          id_mem_to_reg,
   input  logic          id_mem_write,
   input  logic          id_branch,
   input  logic          stall,
   input  logic          flush,
   input  logic          mem_reg_write,
   input  logic [RW-1:0] mem_rd,
   input  logic [DW-1:0] mem_result,
   input  logic          wb_reg_write,
   input  logic [RW-1:0] wb_rd,
   input  logic [DW-1:0] wb_result,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [2:0]    alu_op,
   output logic [DW-1:0] ex_store_data,
   output logic          ex_valid,
   output logic          ex_reg_write,
   output logic          ex_mem_to_reg,
   output logic          ex_mem_write,
   output logic          ex_branch,
   output logic [RW-1:0] ex_rd,
   output logic          load_use_stall
);

   logic          r_valid;
   logic          r_reg_write;
   logic          r_mem_to_reg;
   logic          r_mem_write;
   logic          r_branch;
   logic          r_alu_src;
   logic [2:0]    r_alu_op;
   logic [RW-1:0] r_rs;
   logic [RW-1:0] r_rt;
   logic [RW-1:0] r_rd;
   logic [DW-1:0] r_rs_val;
   logic [DW-1:0] r_rt_val;
   logic [DW-1:0] r_imm;

   logic [DW-1:0] w_rs_fwd;
   logic [DW-1:0] w_rt_fwd;

   // A bubble is the all-zero register image, so reset and flush share a path
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_valid      <= 1'b0;
         r_reg_write  <= 1'b0;
         r_mem_to_reg <= 1'b0;
         r_mem_write  <= 1'b0;
         r_branch     <= 1'b0;
         r_alu_src    <= 1'b0;
         r_alu_op     <= ALU_AND;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_rs_val     <= '0;
         r_rt_val     <= '0;
         r_imm        <= '0;
      end else if (!stall) begin
         r_valid      <= id_valid;
         r_reg_write  <= id_reg_write;
         r_mem_to_reg <= id_mem_to_reg;
         r_mem_write  <= id_mem_write;
         r_branch     <= id_branch;
         r_alu_src    <= id_alu_src;
         r_alu_op     <= id_alu_op;
         r_rs         <= id_rs;
         r_rt         <= id_rt;
         r_rd         <= id_rd;
         r_rs_val     <= id_rs_val;
         r_rt_val     <= id_rt_val;
         r_imm        <= id_imm;
      end
   end

`ifdef EX_FORWARD_EN
   fwd_sel_e w_rs_sel;
   fwd_sel_e w_rt_sel;

   fwd_sel #(.RW(RW)) u_fwd_rs (
      .src           (r_rs),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .sel           (w_rs_sel)
   );

   fwd_sel #(.RW(RW)) u_fwd_rt (
      .src           (r_rt),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .sel           (w_rt_sel)
   );

   always_comb begin
      w_rs_fwd = r_rs_val;
      w_rt_fwd = r_rt_val;
      case (w_rs_sel)
         FWD_MEM: w_rs_fwd = mem_result;
         FWD_WB:  w_rs_fwd = wb_result;
         default: w_rs_fwd = r_rs_val;
      endcase
      case (w_rt_sel)
         FWD_MEM: w_rt_fwd = mem_result;
         FWD_WB:  w_rt_fwd = wb_result;
         default: w_rt_fwd = r_rt_val;
      endcase
   end

   // Loaded data is only available from MEM onward, one cycle too late for EX
   assign load_use_stall = r_valid && r_mem_to_reg && (r_rd != RW'(REG_ZERO)) &&
                           ((r_rd == id_rs) || (r_rd == id_rt));
`else
   logic w_unused_fwd;

   assign w_rs_fwd       = r_rs_val;
   assign w_rt_fwd       = r_rt_val;
   assign load_use_stall = 1'b0;
   assign w_unused_fwd   = ^{r_rs, r_rt, mem_reg_write, mem_rd, mem_result,
                             wb_reg_write, wb_rd, wb_result};
`endif

   assign alu_a         = w_rs_fwd;
   assign alu_b         = r_alu_src ? r_imm : w_rt_fwd;
   assign ex_store_data = w_rt_fwd;
   assign alu_op        = r_alu_op;
   assign ex_valid      = r_valid;
   assign ex_reg_write  = r_reg_write;
   assign ex_mem_to_reg = r_mem_to_reg;
   assign ex_mem_write  = r_mem_write;
   assign ex_branch     = r_branch;
   assign ex_rd         = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
// ============================================================================
// Module   : tb_ex_issue_stage
// Purpose  : Directed self-checking bench for ex_issue_stage; expectations
//            follow whether EX_FORWARD_EN is defined for the build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_issue_stage;
   import mips_pkg::*;

`ifdef EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [31:0] id_rs_val, id_rt_val, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic        id_alu_src;
   logic [2:0]  id_alu_op;
   logic        id_reg_write, id_mem_to_reg, id_mem_write, id_branch;
   logic        stall, flush;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_result, wb_result;
   logic [31:0] alu_a, alu_b, ex_store_data;
   logic [2:0]  alu_op;
   logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch;
   logic [4:0]  ex_rd;
   logic        load_use_stall;

   int vectors = 0;
   int errs    = 0;

   ex_issue_stage #(.DW(32), .RW(5)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_rs_val(id_rs_val), .id_rt_val(id_rt_val),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
      .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
      .id_mem_write(id_mem_write), .id_branch(id_branch),
      .stall(stall), .flush(flush),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .ex_store_data(ex_store_data), .ex_valid(ex_valid),
      .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
      .ex_rd(ex_rd), .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic [4:0] rs, input logic [31:0] rsv,
                         input logic [4:0] rt, input logic [31:0] rtv,
                         input logic [4:0] rd, input logic [2:0] op,
                         input logic src, input logic [31:0] imm,
                         input logic rw, input logic m2r, input logic mw, input logic br);
      id_valid = 1'b1;
      id_rs = rs; id_rs_val = rsv; id_rt = rt; id_rt_val = rtv; id_rd = rd;
      id_alu_op = op; id_alu_src = src; id_imm = imm;
      id_reg_write = rw; id_mem_to_reg = m2r; id_mem_write = mw; id_branch = br;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset with busy ID inputs
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
      wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'h0;
      set_id(5'd3, 32'hAAAA, 5'd4, 32'hBBBB, 5'd5, ALU_SLT, 1'b1, 32'hCCCC,
             1'b1, 1'b1, 1'b1, 1'b1);
      tick; tick;
      chk("rst_alu_a", alu_a, 32'h0);
      chk("rst_alu_b", alu_b, 32'h0);
      chk("rst_alu_op", {29'h0, alu_op}, 32'h0);
      chk("rst_store", ex_store_data, 32'h0);
      chk("rst_ctrl", {27'h0, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch}, 32'h0);
      chk("rst_rd", {27'h0, ex_rd}, 32'h0);
      chk("rst_lus", {31'h0, load_use_stall}, 32'h0);

      // Plain add capture
      rst = 1'b1;
      set_id(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, ALU_ADD, 1'b0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0);
      tick;
      chk("add_alu_a", alu_a, 32'd5);
      chk("add_alu_b", alu_b, 32'd7);
      chk("add_alu_op", {29'h0, alu_op}, {29'h0, ALU_ADD});
      chk("add_ctrl", {26'h0, ex_valid, ex_reg_write, ex_rd}, {26'h0, 1'b1, 1'b1, 5'd3});

      // Double forward on rs=8: MEM beats WB, then WB alone
      set_id(5'd8, 32'h100, 5'd4, 32'h200, 5'd6, ALU_OR, 1'b0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0);
      tick;
      mem_reg_write = 1'b1; mem_rd = 5'd8; mem_result = 32'h11;
      wb_reg_write = 1'b1; wb_rd = 5'd8; wb_result = 32'h22;
      #1;
      chk("fwd_mem_wins", alu_a, FWD ? 32'h11 : 32'h100);
      chk("fwd_rt_nomatch", alu_b, 32'h200);
      mem_reg_write = 1'b0;
      #1;
      chk("fwd_wb", alu_a, FWD ? 32'h22 : 32'h100);
      wb_reg_write = 1'b0;

      // Register 0 is never forwarded
      set_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd7, ALU_ADD, 1'b0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0);
      tick;
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hFF;
      wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hEE;
      #1;
      chk("zero_rs", alu_a, 32'h0);
      chk("zero_rt", alu_b, 32'h0);
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;

      // Load-use: lw rd=9 in EX, consumer reads rt=9
      set_id(5'd10, 32'h1000, 5'd9, 32'h0, 5'd9, ALU_ADD, 1'b1, 32'd4,
             1'b1, 1'b1, 1'b0, 1'b0);
      tick;
      chk("lw_alu_b_imm", alu_b, 32'd4);
      chk("lw_alu_a", alu_a, 32'h1000);
      set_id(5'd11, 32'h0, 5'd9, 32'h0, 5'd12, ALU_ADD, 1'b0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("lus_rt", {31'h0, load_use_stall}, {31'h0, FWD});
      id_rs = 5'd9; id_rt = 5'd12;
      #1;
      chk("lus_rs", {31'h0, load_use_stall}, {31'h0, FWD});
      id_rs = 5'd13; id_rt = 5'd14;
      #1;
      chk("lus_none", {31'h0, load_use_stall}, 32'h0);
      id_rs = 5'd9; id_rt = 5'd12;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("lus_bubble", {27'h0, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch}, 32'h0);
      chk("lus_bubble_op", {29'h0, alu_op}, 32'h0);
      chk("lus_after", {31'h0, load_use_stall}, 32'h0);

      // Load into r0 never requests a stall
      set_id(5'd1, 32'h0, 5'd0, 32'h0, 5'd0, ALU_ADD, 1'b1, 32'h0,
             1'b1, 1'b1, 1'b0, 1'b0);
      tick;
      set_id(5'd0, 32'h0, 5'd0, 32'h0, 5'd2, ALU_ADD, 1'b0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("lus_r0", {31'h0, load_use_stall}, 32'h0);

      // Stall holds for three cycles while ID changes
      set_id(5'd5, 32'h30, 5'd6, 32'h10, 5'd7, ALU_SUB, 1'b0, 32'h0,
             1'b1, 1'b0, 1'b0, 1'b1);
      tick;
      stall = 1'b1;
      set_id(5'd1, 32'h5555, 5'd2, 32'h6666, 5'd3, ALU_OR, 1'b1, 32'h7777,
             1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("stall_alu_a", alu_a, 32'h30);
         chk("stall_alu_b", alu_b, 32'h10);
         chk("stall_ctrl", {21'h0, alu_op, ex_valid, ex_reg_write, ex_mem_to_reg,
                            ex_mem_write, ex_branch, ex_rd},
             {21'h0, ALU_SUB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7});
      end
      mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'h99;
      #1;
      chk("stall_pickup", alu_a, FWD ? 32'h99 : 32'h30);
      mem_reg_write = 1'b0;

      // Stall and flush together: flush wins
      flush = 1'b1;
      tick;
      flush = 1'b0; stall = 1'b0;
      chk("sf_bubble", {26'h0, ex_valid, ex_branch, ex_rd}, 32'h0);

      // sw: immediate on B, forwarded rt on store data
      set_id(5'd2, 32'h8, 5'd13, 32'h1, 5'd0, ALU_ADD, 1'b1, 32'hFFFF_FFFC,
             1'b0, 1'b0, 1'b1, 1'b0);
      tick;
      wb_reg_write = 1'b1; wb_rd = 5'd13; wb_result = 32'h40;
      #1;
      chk("sw_alu_b", alu_b, 32'hFFFF_FFFC);
      chk("sw_store", ex_store_data, FWD ? 32'h40 : 32'h1);
      chk("sw_alu_a", alu_a, 32'h8);
      chk("sw_mw", {31'h0, ex_mem_write}, 32'h1);
      wb_reg_write = 1'b0;

      // Reset during stall clears registers
      stall = 1'b1; rst = 1'b0;
      tick;
      chk("rst_stall", {27'h0, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch}, 32'h0);
      chk("rst_stall_b", alu_b, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline register and operand-forwarding front end of the 5-stage MIPS core. It captures decoded instruction fields at the ID→EX boundary and resolves RAW hazards by forwarding MEM/WB results. It drives the 32-bit operands and 3-bit ALUControl into the EX-stage ALU. It also raises the load-use stall request consumed by the hazard unit.

## Interface
- Parameters:
- `DW`, default 32: datapath width.
- `RW`, default 5: register-number width.
- Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `id_valid`  in  1: ID holds a real instruction.
- `id_rs_val`, `id_rt_val`  in  DW: register-file read data.
- `id_rs`, `id_rt`, `id_rd`  in  RW: source numbers and destination number (destination already selected rt/rd).
- `id_imm`  in  DW: sign-extended immediate.
- `id_alu_src`  in  1: 1 = operand B is the immediate.
- `id_alu_op`  in  3: ALUControl code.
- `id_reg_write`, `id_mem_to_reg`, `id_mem_write`, `id_branch`  in  1: control bits.
- `stall`  in  1: hold the EX register.
- `flush`  in  1: load a bubble.
- `mem_reg_write`  in  1; `mem_rd`  in  RW; `mem_result`  in  DW: forwarding source from MEM.
- `wb_reg_write`  in  1; `wb_rd`  in  RW; `wb_result`  in  DW: forwarding source from WB.
- `alu_a`, `alu_b`  out  DW: ALU operands.
- `alu_op`  out  3: registered ALUControl.
- `ex_store_data`  out  DW: forwarded rt for sw.
- `ex_valid`, `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_write`, `ex_branch`  out  1: registered control.
- `ex_rd`  out  RW: registered destination.
- `load_use_stall`  out  1: hazard request to freeze PC/IF/ID.

## Operation
- Register update per edge, in priority order:
  - `rst`=0: all registers cleared.
  - else `flush`=1: bubble loaded.
  - else `stall`=1: all registers hold.
  - else: all `id_*` fields captured.
- Bubble: `ex_valid`, `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_write`, `ex_branch` = 0; data fields are don't-care but are driven to 0.
- Forwarding is combinational on the registered rs/rt numbers. The same rule is applied independently for rs and rt:
  - MEM match (`mem_reg_write` and `mem_rd`==src and src≠0) → `mem_result`.
  - else WB match → `wb_result`.
  - else the registered register-file value.
- MEM wins over WB when both match.
- Register 0 is never forwarded.
- `alu_a` = forwarded rs.
- `alu_b` = registered immediate if alu_src, else forwarded rt.
- `ex_store_data` = forwarded rt, regardless of alu_src.
- `load_use_stall` = `ex_valid` & `ex_mem_to_reg` & `ex_rd`≠0 & (`ex_rd`==`id_rs` | `ex_rd`==`id_rt`). Combinational.
- The hazard unit answers `load_use_stall` by asserting `flush` on this block in the same cycle.
- Control and data outputs other than the forwarded operands are direct register outputs.

## Timing
- Latency: `id_*` values appear on the `ex_*` outputs one cycle after capture.
- `alu_a`/`alu_b` additionally track `mem_*`/`wb_*` changes in the same cycle (zero-cycle combinational path).
- Reset values: all registered outputs are 0. `alu_op`=3'b000, `ex_valid`=0.
- `alu_a`, `alu_b`, `ex_store_data` = 0 after reset, provided `mem_reg_write`=`wb_reg_write`=0.
- `load_use_stall`=0 in the cycle after reset.
- `flush` and `stall` together: flush wins.
- Reset asserted mid-stall: registers clear on the next edge; the stall is irrelevant.
- A stalled instruction re-evaluates forwarding every cycle, so it picks up results retiring while it is held.

## Configuration
- `EX_FORWARD_EN` defined:
  - Forwarding muxes present as described.
  - `load_use_stall` active.
- `EX_FORWARD_EN` undefined:
  - Operands come straight from the registered register-file values.
  - `load_use_stall` is tied 0.
  - The hazard unit must then stall for every RAW dependency.
  - `mem_*`/`wb_*` inputs are ignored.

## Structure
- Shared package `mips_pkg`:
  - ALUControl constants: AND 3'b000, OR 3'b001, ADD 3'b010, SUB 3'b110, SLT 3'b111.
  - `REG_ZERO` = 5'd0.
  - Forward-select enum: FWD_RF, FWD_MEM, FWD_WB.
- One sub-module `fwd_sel`, instantiated twice (rs, rt): it takes the source number and the MEM/WB write info and returns the forward-select enum.

## Test plan
- Reset: hold `rst`=0 two cycles with id inputs nonzero → all outputs 0, `ex_valid`=0.
- Plain capture: add, rs_val=5, rt_val=7, alu_op=3'b010 → next cycle `alu_a`=5, `alu_b`=7, `alu_op`=3'b010.
- Double forward: registered rs=8; `mem_rd`=8 with result 0x11; `wb_rd`=8 with result 0x22 → `alu_a`=0x11. Drop the MEM write → `alu_a`=0x22.
- Zero register: rs=0, `mem_rd`=0, `mem_reg_write`=1, result 0xFF → `alu_a`=registered rf value (0).
- Load-use: EX holds lw with rd=9; ID has rt=9 → `load_use_stall`=1. Bench asserts `flush` → next cycle `ex_valid`=0, `ex_reg_write`=0.
- Stall/flush priority and immediate path: `stall`=1 holds all outputs for 3 cycles. `stall`=`flush`=1 → bubble. sw with alu_src=1, imm=0xFFFFFFFC, forwarded rt=0x40 → `alu_b`=0xFFFFFFFC, `ex_store_data`=0x40.
